adc: RTL and testbench

Controller for an ADC0804-style 8-bit parallel ADC with chip-select, write-start, read and interrupt handshake. Generates the converter's clock, starts conversions continuously, waits for end-of-conversion (`intr` low), reads the data bus and holds the last result on `adc_data_conv`. Sits between the board-level ADC pins and system logic in the `clk` domain.

---
 rtl/adc_pkg.sv | 15 +
 rtl/adc_clk_gen.sv | 36 +++
 rtl/adc.sv | 112 +++++++++++
 tb/tb_adc.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and default timing constants for the ADC0804-style controller.
package adc_pkg;

  typedef enum logic [1:0] {
    StStart,
    StWaitEoc,
    StRead,
    StRelease
  } adc_state_e;

  localparam int unsigned DefClkDiv   = 80;
  localparam int unsigned DefWrCycles = 10;
  localparam int unsigned DefRdCycles = 20;

endpackage

// File: rtl/adc_clk_gen.sv
// Free-running divider: toggles adc_clk every CLK_DIV system clocks.
module adc_clk_gen #(
  parameter int unsigned CLK_DIV = 80
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic adc_clk_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            clk_q, clk_d;

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    clk_d = clk_q;
    if (cnt_q == CntW'(CLK_DIV - 1)) begin
      cnt_d = '0;
      clk_d = ~clk_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  assign adc_clk_o = clk_q;

endmodule

// File: rtl/adc.sv
// ADC0804 handshake controller: start pulse, wait for EOC, timed read, wait for INTR release.
module adc
  import adc_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DefClkDiv,
  parameter int unsigned WR_CYCLES = DefWrCycles,
  parameter int unsigned RD_CYCLES = DefRdCycles
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       intr,
  input  logic [7:0] data_ip,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       adc_clk,
  output logic [7:0] adc_data_conv
);

  localparam int unsigned MaxCyc = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  adc_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            intr_meta_q, intr_s_q;
  logic            cs_n_q, rd_n_q, wr_n_q;
  logic            cs_n_d, rd_n_d, wr_n_d;

  adc_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .adc_clk_o (adc_clk)
  );

  // cnt_q counts strobe-low cycles already driven; entering a strobe state counts as the first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      StStart: begin
        if (cnt_q == CntW'(WR_CYCLES)) begin
          state_d = StWaitEoc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitEoc: begin
        if (!intr_s_q) begin
          state_d = StRead;
          cnt_d   = CntW'(1);
        end
      end
      StRead: begin
        if (cnt_q == CntW'(RD_CYCLES)) begin
          state_d = StRelease;
          cnt_d   = '0;
          data_d  = data_ip;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (intr_s_q) begin
          state_d = StStart;
          cnt_d   = CntW'(1);
        end
      end
      default: begin
        state_d = StStart;
        cnt_d   = '0;
      end
    endcase

    // Strobes follow the next state so they change on the transition edge itself.
    wr_n_d = (state_d != StStart);
    rd_n_d = (state_d != StRead);
    cs_n_d = !((state_d == StStart) || (state_d == StRead));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StStart;
      cnt_q       <= '0;
      data_q      <= 8'h00;
      intr_meta_q <= 1'b1;
      intr_s_q    <= 1'b1;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      intr_meta_q <= intr;
      intr_s_q    <= intr_meta_q;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
    end
  end

  assign cs_n          = cs_n_q;
  assign rd_n          = rd_n_q;
  assign wr_n          = wr_n_q;
  assign adc_data_conv = data_q;

endmodule

// File: tb/tb_adc.sv
// Directed/randomized bench for adc: handshake latencies, data capture, hold, reset and divider.
module tb_adc;

  localparam int ClkDiv   = 80;
  localparam int WrCycles = 10;
  localparam int RdCycles = 20;
  localparam int ClkNs    = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       intr;
  logic [7:0] data_ip;
  logic       cs_n, rd_n, wr_n, adc_clk;
  logic [7:0] adc_data_conv;

  int n_vec = 0;
  int n_err = 0;

  adc dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .intr          (intr),
    .data_ip       (data_ip),
    .cs_n          (cs_n),
    .rd_n          (rd_n),
    .wr_n          (wr_n),
    .adc_clk       (adc_clk),
    .adc_data_conv (adc_data_conv)
  );

  always #(ClkNs / 2) clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      0:       return wr_n;
      1:       return rd_n;
      default: return adc_clk;
    endcase
  endfunction

  // Counts falling clk edges until the selected output reaches val (bounded).
  task automatic wait_for(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (pick(sel) !== val && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] model_data;   // last sample the controller should be holding
  int         n, extra_reads, low_total, hi_cyc, lo_cyc;
  logic [7:0] sample;

  initial begin
    rst_n      = 1'b0;
    intr       = 1'b1;
    data_ip    = 8'($urandom);
    model_data = 8'h00;
    step(5);

    check("rst_cs_n", cs_n, 1);
    check("rst_rd_n", rd_n, 1);
    check("rst_wr_n", wr_n, 1);
    check("rst_adc_clk", adc_clk, 0);
    check("rst_data", adc_data_conv, 0);

    // Start pulse after reset release.
    rst_n = 1'b1;
    wait_for(0, 1'b0, 50, n);
    check("first_wr_fall", n, 1);
    check("first_cs_low", cs_n, 0);
    wait_for(0, 1'b1, 50, n);
    check("first_wr_width", n, WrCycles);
    check("wait_cs_high", cs_n, 1);
    step(200);
    check("idle_wr_n", wr_n, 1);
    check("idle_rd_n", rd_n, 1);

    // Conversions: first two use the fixed samples, the rest are random.
    for (int k = 0; k < 6; k++) begin
      data_ip = 8'($urandom);
      step(7);
      check("hold_wait_eoc", adc_data_conv, model_data);

      sample    = (k == 0) ? 8'h0A : (k == 1) ? 8'hF3 : 8'($urandom);
      low_total = (k == 0) ? 1050 : $urandom_range(30, 300);
      data_ip   = sample;
      intr      = 1'b0;
      wait_for(1, 1'b0, 50, n);
      check("intr_to_rd_fall", n, 3);
      check("read_cs_low", cs_n, 0);
      wait_for(1, 1'b1, 100, n);
      check("rd_width", n, RdCycles);
      model_data = sample;
      check("read_data", adc_data_conv, model_data);
      check("release_cs_high", cs_n, 1);

      extra_reads = 0;
      for (int i = 0; i < low_total - 3 - RdCycles; i++) begin
        @(negedge clk);
        if (i == 4) data_ip = ~sample;
        if (rd_n === 1'b0) extra_reads++;
      end
      check("single_read", extra_reads, 0);
      check("hold_release", adc_data_conv, model_data);

      intr = 1'b1;
      wait_for(0, 1'b0, 50, n);
      check("intr_to_wr_fall", n, 3);
      wait_for(0, 1'b1, 50, n);
      check("restart_wr_width", n, WrCycles);
    end

    // Asynchronous reset in the middle of a read.
    data_ip = 8'h5C;
    intr    = 1'b0;
    wait_for(1, 1'b0, 50, n);
    check("mid_read_rd_fall", n, 3);
    step(5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_n", rd_n, 1);
    check("async_cs_n", cs_n, 1);
    check("async_wr_n", wr_n, 1);
    check("async_adc_clk", adc_clk, 0);
    check("async_data", adc_data_conv, 0);
    model_data = 8'h00;
    step(3);
    intr = 1'b1;

    // Divider timing measured from release while the FSM keeps working.
    @(negedge clk);
    rst_n = 1'b1;
    fork
      begin
        wait_for(2, 1'b1, 400, n);
        check("adc_clk_first_rise", n, ClkDiv);
        wait_for(2, 1'b0, 400, hi_cyc);
        wait_for(2, 1'b1, 400, lo_cyc);
        check("adc_clk_high", hi_cyc, ClkDiv);
        check("adc_clk_low", lo_cyc, ClkDiv);
        check("adc_clk_period_ns", (hi_cyc + lo_cyc) * ClkNs, 1600);
      end
      begin
        wait_for(0, 1'b0, 50, n);
        check("rerun_wr_fall", n, 1);
        step(40);
        data_ip = 8'hC7;
        intr    = 1'b0;
        step(60);
        intr = 1'b1;
        model_data = 8'hC7;
        check("rerun_data", adc_data_conv, model_data);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
